// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase controller: FSM states, lamp encodings
// and the round-robin approach selector. ST_PED exists only with TRAFFIC_PED_EN.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
`ifdef TRAFFIC_PED_EN
    ST_YELLOW  = 2'd2,
    ST_PED     = 2'd3
`else
    ST_YELLOW  = 2'd2
`endif
  } state_e;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  // First requesting approach at or after start (wrapping over n approaches);
  // with no request at all the start position itself is returned.
  function automatic logic [1:0] rr_next(input logic [3:0] req,
                                         input logic [1:0] start,
                                         input logic [2:0] n);
    logic [1:0] pick;
    logic       found;
    logic [2:0] idx;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = {1'b0, start} + 3'(i);
      idx = (idx >= n) ? (idx - n) : idx;
      if (!found && (3'(i) < n) && req[idx[1:0]]) begin
        pick  = idx[1:0];
        found = 1'b1;
      end else begin
        pick  = pick;
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/traffic_phase_controller_timer.sv
// Loadable TW-bit down-counter that parks at zero; zero marks the last cycle
// of the current duration.
module phase_timer #(
  parameter int            TW      = 8,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [TW-1:0] value,
  output logic          zero
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Next count: load wins, otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/traffic_phase_controller.sv
// N-approach round-robin signal controller with demand skipping and bounded
// green extension. Define TRAFFIC_PED_EN to add the pedestrian walk phase.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int N_DIR       = 2,
  parameter int TW          = 8,
  parameter int T_GREEN     = 8,
  parameter int T_GREEN_EXT = 4,
  parameter int MAX_EXT     = 2,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 6,
  localparam int PW         = $clog2(N_DIR)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_DIR-1:0]   req,
  input  logic [N_DIR-1:0]   high,
`ifdef TRAFFIC_PED_EN
  input  logic               ped_req,
  output logic               walk,
`endif
  output logic [3*N_DIR-1:0] light,
  output logic [PW-1:0]      phase,
  output logic               ext_active
);

  localparam int EW = (MAX_EXT < 1) ? 1 : $clog2(MAX_EXT + 1);

  if (N_DIR < 2 || N_DIR > 4) begin : g_bad_ndir
    $error("traffic_phase_controller: N_DIR must be 2..4");
  end
  if (T_GREEN < 1 || T_GREEN_EXT < 1 || T_YELLOW < 1 || T_ALLRED < 1 || T_WALK < 1) begin : g_bad_dur
    $error("traffic_phase_controller: every duration must be at least 1");
  end
  if (MAX_EXT < 0) begin : g_bad_ext
    $error("traffic_phase_controller: MAX_EXT must be non-negative");
  end
  if (T_GREEN > 2**TW || T_GREEN_EXT > 2**TW || T_YELLOW > 2**TW ||
      T_ALLRED > 2**TW || T_WALK > 2**TW) begin : g_bad_tw
    $error("traffic_phase_controller: a duration does not fit the timer width");
  end

  state_e             state_q, state_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic [EW-1:0]      ext_cnt_q, ext_cnt_d;
  logic               ext_q, ext_d;
  logic               first_q, first_d;
  logic [3*N_DIR-1:0] light_q, light_d;
  logic               t_load;
  logic [TW-1:0]      t_value;
  logic               t_zero;
  logic [3:0]         req_ext;
  logic [1:0]         rr_start;
  logic [1:0]         rr_pick;
`ifdef TRAFFIC_PED_EN
  logic               ped_q, ped_d;
  logic               walk_q, walk_d;
`endif

  phase_timer #(
    .TW      (TW),
    .RST_VAL (TW'(T_ALLRED - 1))
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (t_load),
    .value   (t_value),
    .zero    (t_zero)
  );

  // Round-robin candidate: search from phase+1, or from 0 before the first green.
  always_comb begin
    req_ext             = '0;
    req_ext[N_DIR-1:0]  = req;
    if (first_q) begin
      rr_start = 2'd0;
    end else if (2'(phase_q) == 2'(N_DIR - 1)) begin
      rr_start = 2'd0;
    end else begin
      rr_start = 2'(phase_q) + 2'd1;
    end
    rr_pick = rr_next(req_ext, rr_start, 3'(N_DIR));
  end

  // Next-state, timer control and registered-output preparation.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    ext_cnt_d = ext_cnt_q;
    ext_d     = ext_q;
    first_d   = first_q;
    t_load    = 1'b0;
    t_value   = '0;
`ifdef TRAFFIC_PED_EN
    ped_d     = ped_q | ped_req;
`endif
    case (state_q)
      ST_ALL_RED: begin
        if (t_zero) begin
          state_d   = ST_GREEN;
          phase_d   = PW'(rr_pick);
          ext_cnt_d = '0;
          ext_d     = 1'b0;
          first_d   = 1'b0;
          t_load    = 1'b1;
          t_value   = TW'(T_GREEN - 1);
        end else begin
          state_d   = ST_ALL_RED;
        end
      end
      ST_GREEN: begin
        if (t_zero && high[phase_q] && (ext_cnt_q < EW'(MAX_EXT))) begin
          ext_cnt_d = ext_cnt_q + 1'b1;
          ext_d     = 1'b1;
          t_load    = 1'b1;
          t_value   = TW'(T_GREEN_EXT - 1);
        end else if (t_zero) begin
          state_d   = ST_YELLOW;
          ext_d     = 1'b0;
          t_load    = 1'b1;
          t_value   = TW'(T_YELLOW - 1);
        end else begin
          state_d   = ST_GREEN;
        end
      end
      ST_YELLOW: begin
`ifdef TRAFFIC_PED_EN
        if (t_zero && ped_q) begin
          state_d = ST_PED;
          ped_d   = 1'b0;
          t_load  = 1'b1;
          t_value = TW'(T_WALK - 1);
        end else if (t_zero) begin
`else
        if (t_zero) begin
`endif
          state_d = ST_ALL_RED;
          t_load  = 1'b1;
          t_value = TW'(T_ALLRED - 1);
        end else begin
          state_d = ST_YELLOW;
        end
      end
`ifdef TRAFFIC_PED_EN
      ST_PED: begin
        if (t_zero) begin
          state_d = ST_ALL_RED;
          t_load  = 1'b1;
          t_value = TW'(T_ALLRED - 1);
        end else begin
          state_d = ST_PED;
        end
      end
`endif
      default: begin
        state_d = ST_ALL_RED;
        ext_d   = 1'b0;
        t_load  = 1'b1;
        t_value = TW'(T_ALLRED - 1);
      end
    endcase

    // Lamps follow the state being entered so they change together with it.
    light_d = '0;
    for (int d = 0; d < N_DIR; d++) begin
      if (state_d == ST_GREEN && phase_d == PW'(d)) begin
        light_d[3*d +: 3] = LT_GRN;
      end else if (state_d == ST_YELLOW && phase_d == PW'(d)) begin
        light_d[3*d +: 3] = LT_YEL;
      end else begin
        light_d[3*d +: 3] = LT_RED;
      end
    end
`ifdef TRAFFIC_PED_EN
    walk_d = (state_d == ST_PED);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_ALL_RED;
      phase_q   <= '0;
      ext_cnt_q <= '0;
      ext_q     <= 1'b0;
      first_q   <= 1'b1;
      light_q   <= {N_DIR{LT_RED}};
`ifdef TRAFFIC_PED_EN
      ped_q     <= 1'b0;
      walk_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ext_cnt_q <= ext_cnt_d;
      ext_q     <= ext_d;
      first_q   <= first_d;
      light_q   <= light_d;
`ifdef TRAFFIC_PED_EN
      ped_q     <= ped_d;
      walk_q    <= walk_d;
`endif
    end
  end

  assign light      = light_q;
  assign phase      = phase_q;
  assign ext_active = ext_q;
`ifdef TRAFFIC_PED_EN
  assign walk       = walk_q;
`endif

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Parametrised successor to the two-way advanced traffic FSM. It drives `N_DIR` signal groups (2 to 4 approaches) through round-robin GREEN, YELLOW and ALL_RED phases. Approaches with no vehicle demand are skipped, and green is extended under heavy traffic up to a bounded count. The block sits at intersection top level, fed by debounced detector inputs, and drives the lamp drivers directly from registered outputs.

## Interface
- `N_DIR`, 2: number of approaches, legal 2..4.
- `TW`, 8: timer width in bits; every duration must be ≤ 2^TW.
- `T_GREEN`, 8: base green length in cycles, ≥1.
- `T_GREEN_EXT`, 4: cycles added per extension, ≥1.
- `MAX_EXT`, 2: maximum extensions per green, ≥0.
- `T_YELLOW`, 3: yellow length in cycles, ≥1.
- `T_ALLRED`, 2: all-red clearance length in cycles, ≥1.
- `T_WALK`, 6: pedestrian walk length in cycles. Used only with `TRAFFIC_PED_EN`.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous active-low reset.
- `req` in N_DIR: vehicle present per approach, level.
- `high` in N_DIR: heavy traffic per approach, level.
- `light` out 3*N_DIR: per approach `{R,Y,G}`, with approach d at bits [3d+2:3d]. Each field is one-hot.
- `phase` out $clog2(N_DIR): index of the approach currently served.
- `ext_active` out 1: high while the current green is in an extension.
- `ped_req` in 1: pedestrian button. Exists only with `TRAFFIC_PED_EN`.
- `walk` out 1: walk lamp. Exists only with `TRAFFIC_PED_EN`.

## Operation
- States: `ALL_RED`, `GREEN`, `YELLOW`, and `PED` (macro only).
- Duration timer: loads duration-1 on state entry and decrements each cycle. The state exits on the cycle where timer==0, so each state lasts exactly its duration.
- `ALL_RED`: every light is `100`. On exit it selects the next approach:
  - Round-robin search starts at `phase+1`, or at 0 after reset, and wraps. The search includes `phase` itself as the last candidate.
  - The first d with `req[d]`=1 wins.
  - If `req` is all zero, the next approach is `phase+1` mod N_DIR (plain rotation).
  - `phase` updates on entry to `GREEN`.
- `GREEN`: `phase` shows `001` and every other approach shows `100`. Extension rule:
  - Applies on the final cycle of the current green segment (timer==0).
  - If `high[phase]`=1 and ext_cnt<MAX_EXT: reload T_GREEN_EXT-1, increment ext_cnt, set `ext_active`, and stay in `GREEN`.
  - Otherwise go to `YELLOW`.
  - ext_cnt clears on entry to `GREEN`.
- `YELLOW`: `phase` shows `010` and all others show `100`. Exits to `ALL_RED`, or to `PED` when a pedestrian request is pending (macro only).
- Safety invariant: at most one approach is non-red at any time. Simultaneous R/Y/G within one approach is illegal.
- `req`/`high` changes mid-green affect only the next extension check or the next selection. They never cut a green short.

## Timing
- Reset values: state `ALL_RED` with timer=T_ALLRED-1; `light` all `100`; `phase`=0; `ext_active`=0; ext_cnt=0; `walk`=0; ped pending=0.
- Reset assertion mid-phase forces these values immediately, independent of `clk`.
- All outputs are registered and change only on `clk` edges following a state or timer event. There is no combinational path from input to output.
- Inputs are sampled on the decision cycle only: the `ALL_RED` exit for `req`, and the green timer==0 cycle for `high`.
- Maximum green = T_GREEN + MAX_EXT·T_GREEN_EXT.
- Cycle of one approach with no extensions = T_GREEN + T_YELLOW + T_ALLRED.

## Configuration
- `TRAFFIC_PED_EN` defined:
  - Adds the `ped_req` and `walk` ports.
  - A `ped_req` high on any cycle sets a sticky pending flag.
  - On `YELLOW` exit with pending set, the FSM enters `PED` for T_WALK cycles: all lights `100`, `walk`=1. Pending clears on `PED` entry.
  - `PED` exits to `ALL_RED`.
  - A `ped_req` arriving during `PED` re-arms pending for the next cycle.
- `TRAFFIC_PED_EN` undefined: the ports, flag and `PED` state are absent; `T_WALK` is ignored.

## Structure
- Package `traffic_pkg` holds:
  - the state enum;
  - light encodings `LT_RED`=3'b100, `LT_YEL`=3'b010, `LT_GRN`=3'b001;
  - a round-robin next-approach function.
- Sub-module `phase_timer`: a TW-bit loadable down-counter with `load`, `value` and a `zero` flag.
- Legal-parameter checks are elaboration-time assertions.

## Test plan
All scenarios use default parameters. t=0 is the first edge after `reset_n` rises.
- `req`=2'b11, `high`=0 → all-red t0–1, dir0 green t2–9, yellow t10–12, all-red t13–14, dir1 green t15–22. Period 26.
- `req`=2'b11, `high`=2'b01 → dir0 green lasts 16 cycles with `ext_active` high for the last 8; dir1 green lasts 8.
- `req`=2'b01 → dir0 re-served every 13 cycles and dir1 never goes green; `req`=0 → plain rotation 0,1,0,….
- `reset_n` pulled low mid-yellow → same cycle, all lights `100`, `phase`=0; after release, the sequence restarts as in the first scenario.
- `TRAFFIC_PED_EN`, 1-cycle `ped_req` during dir0 green → after yellow, `walk`=1 for 6 cycles with all red, then all-red 2 cycles, then dir1 green.
- Throughout all scenarios, an assertion checks that at most one approach is non-red and that each `light` field is one-hot.
